// File: rtl/sc_pkg.sv
// Shared types and defaults for the stochastic-computing edge pipeline.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } sc_acc_state_t;

    localparam int SC_DEFAULT_LEN = 256;

endpackage

// File: rtl/sc_edge_accumulator_if.sv
// Window control, sample stream and result handshake for sc_edge_accumulator.
interface sc_edge_accumulator_if #(
    parameter int CNT_W = $clog2(sc_pkg::SC_DEFAULT_LEN) + 1
);
    logic             start;
    logic             bit_in;
    logic             in_valid;
    logic [CNT_W-1:0] thresh;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             edge_flag;

    modport master (
        output start, bit_in, in_valid, thresh, out_ready,
        input  busy, out_valid, count, edge_flag
    );

    modport slave (
        input  start, bit_in, in_valid, thresh, out_ready,
        output busy, out_valid, count, edge_flag
    );
endinterface

// File: rtl/sc_window_counter.sv
// Purpose: counts ones and valid samples within one window.
// Latency: sum/last update one cycle after en or clear.
// Backpressure: none; en low simply holds both counters.
module sc_window_counter #(
    parameter int LEN   = sc_pkg::SC_DEFAULT_LEN,
    parameter int CNT_W = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] sum,
    output logic             last
);
    localparam int IDX_W = $clog2(LEN);

    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
            acc_q <= '0;
        end else if (en) begin
            idx_q <= idx_q + IDX_W'(1);
            acc_q <= acc_q + CNT_W'(bit_in);
        end
    end

    assign sum  = acc_q;
    assign last = (idx_q == IDX_W'(LEN - 1));
endmodule

// File: rtl/sc_edge_accumulator.sv
// Purpose: converts a unipolar bitstream to a ones-count per LEN-sample window, with edge flag.
// Latency: result valid the cycle after the LEN-th valid sample (LEN+1 cycles minimum from start).
// Backpressure: result held in HOLD until out_ready; start is ignored while held.
module sc_edge_accumulator
    import sc_pkg::*;
#(
    parameter int LEN   = SC_DEFAULT_LEN,
    parameter int CNT_W = $clog2(LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sc_edge_accumulator_if.slave  io
);
    sc_acc_state_t    state_q, state_d;
    logic             take_start;
    logic             win_en;
    logic             win_last;
    logic             load_result;
    logic [CNT_W-1:0] win_sum;
    logic [CNT_W-1:0] final_sum;
    logic [CNT_W-1:0] thresh_q;
    logic [CNT_W-1:0] count_q;
    logic             edge_q;

    sc_window_counter #(
        .LEN   (LEN),
        .CNT_W (CNT_W)
    ) u_window_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (take_start),
        .en     (win_en),
        .bit_in (io.bit_in),
        .sum    (win_sum),
        .last   (win_last)
    );

    // The closing sample is still in flight, so fold it into the result here.
    assign final_sum = win_sum + CNT_W'(io.bit_in);

    always_comb begin
        state_d     = state_q;
        take_start  = 1'b0;
        win_en      = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d    = ACCUM;
                    take_start = 1'b1;
                end
            end
            ACCUM: begin
                win_en = io.in_valid;
                if (io.in_valid && win_last) begin
                    state_d     = HOLD;
                    load_result = 1'b1;
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    if (io.start) begin
                        state_d    = ACCUM;
                        take_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            thresh_q <= '0;
            count_q  <= '0;
            edge_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_start) begin
                thresh_q <= io.thresh;
            end
            if (load_result) begin
                count_q <= final_sum;
                edge_q  <= (final_sum >= thresh_q);
            end
        end
    end

    assign io.busy      = (state_q == ACCUM);
    assign io.out_valid = (state_q == HOLD);
    assign io.count     = count_q;
    assign io.edge_flag = edge_q;
endmodule
